ifetch_queue: RTL and testbench

Instruction prefetch queue sitting between the instruction memory and the IF/ID pipeline register. It owns the fetch address, runs a request/acknowledge handshake with a variable-latency instruction memory, and buffers up to DEPTH fetched {instruction, PC} pairs. It presents them to IF/ID under a valid/ready handshake. On a taken branch from the condition handler it flushes all buffered and in-flight fetches and restarts at the target address.

---
 rtl/ifetch_queue_pkg.sv | 24 ++
 rtl/ifetch_queue_if.sv | 25 ++
 rtl/ifetch_queue_fifo.sv | 56 +++++
 rtl/ifetch_queue.sv | 114 +++++++++++
 tb/tb_ifetch_queue.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ifetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package ifetch_queue_pkg;

  localparam int          INST_W = 32;
  localparam int          PC_W   = 32;
  localparam logic [31:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    IFQ_IDLE    = 2'd0,
    IFQ_REQ     = 2'd1,
    IFQ_DISCARD = 2'd2
  } ifq_state_e;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
  } ifq_entry_t;

  // Sequential fetch address; wraps modulo 2^32.
  function automatic logic [PC_W-1:0] next_pc(input logic [PC_W-1:0] pc);
    return pc + PC_INC;
  endfunction

endpackage

// File: rtl/ifetch_queue_if.sv
// Instruction-memory, redirect and IF/ID handshake bundle of the prefetch queue.
interface ifetch_queue_if import ifetch_queue_pkg::*; #(
  parameter int IM_AW = 8
);
  logic              redirect;
  logic [PC_W-1:0]   redirect_pc;
  logic              mem_req;
  logic [IM_AW-1:0]  mem_addr;
  logic              mem_ack;
  logic [INST_W-1:0] mem_data;
  logic              out_valid;
  logic [INST_W-1:0] out_inst;
  logic [PC_W-1:0]   out_pc;
  logic              out_ready;

  modport master (
    input  redirect, redirect_pc, mem_ack, mem_data, out_ready,
    output mem_req, mem_addr, out_valid, out_inst, out_pc
  );

  modport slave (
    output redirect, redirect_pc, mem_ack, mem_data, out_ready,
    input  mem_req, mem_addr, out_valid, out_inst, out_pc
  );
endinterface

// File: rtl/ifetch_queue_fifo.sv
// Circular buffer of {instruction, PC} entries with flush; head is read straight from storage.
module ifetch_queue_fifo import ifetch_queue_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  input  ifq_entry_t    i_wdata,
  output ifq_entry_t    o_rdata,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  localparam int AW = $clog2(DEPTH);

  ifq_entry_t    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_wr_en;
  logic          w_rd_en;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_wr_en = i_push && !o_full;
  assign w_rd_en = i_pop && !o_empty;

  // Flush only rewinds pointers; stale storage is never exposed because count is zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_wr_en) - CW'(w_rd_en);
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, talks to instruction memory, buffers for IF/ID.
// state   | meaning
// IDLE    | queue full (or just reset), no request outstanding
// REQ     | request outstanding, response will be queued
// DISCARD | request outstanding from before a redirect, response will be dropped
module ifetch_queue import ifetch_queue_pkg::*; #(
  parameter int          DEPTH    = 4,
  parameter int          IM_AW    = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  ifetch_queue_if.master  bus
);

  localparam int CW = $clog2(DEPTH + 1);

  ifq_state_e      r_state;
  ifq_state_e      w_state_nxt;
  logic [PC_W-1:0] r_fetch_pc;
  logic [PC_W-1:0] w_fetch_pc_nxt;
  logic [PC_W-1:0] r_req_pc;
  logic [PC_W-1:0] w_req_pc_nxt;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  logic            w_room;
  logic [CW-1:0]   w_count;
  logic [CW-1:0]   w_count_nxt;
  ifq_entry_t      w_head;
  ifq_entry_t      w_wdata;

  assign bus.out_valid = !w_empty && !bus.redirect;
  assign w_pop         = bus.out_valid && bus.out_ready;
  assign w_push        = (r_state == IFQ_REQ) && bus.mem_ack && !bus.redirect && !w_full;
  assign w_count_nxt   = bus.redirect ? '0 : (w_count + CW'(w_push) - CW'(w_pop));
  assign w_room        = (w_count_nxt < CW'(DEPTH));

  assign w_wdata.inst  = bus.mem_data;
  assign w_wdata.pc    = r_req_pc;

  ifetch_queue_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (bus.redirect),
    .i_wdata (w_wdata),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IFQ_IDLE;
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= RESET_PC;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_req_pc   <= w_req_pc_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_req_pc_nxt   = r_req_pc;
    case (r_state)
      IFQ_IDLE: begin
        if (bus.redirect) begin
          w_state_nxt    = IFQ_REQ;
          w_fetch_pc_nxt = bus.redirect_pc;
          w_req_pc_nxt   = bus.redirect_pc;
        end else if (w_room) begin
          w_state_nxt  = IFQ_REQ;
          w_req_pc_nxt = r_fetch_pc;
        end
      end
      IFQ_REQ: begin
        if (bus.redirect) begin
          w_fetch_pc_nxt = bus.redirect_pc;
          if (bus.mem_ack) w_req_pc_nxt = bus.redirect_pc;
          else             w_state_nxt  = IFQ_DISCARD;
        end else if (bus.mem_ack) begin
          w_fetch_pc_nxt = next_pc(r_req_pc);
          if (w_room) w_req_pc_nxt = next_pc(r_req_pc);
          else        w_state_nxt  = IFQ_IDLE;
        end
      end
      IFQ_DISCARD: begin
        // A redirect in the same cycle as the ack still wins over the stored target.
        if (bus.redirect) w_fetch_pc_nxt = bus.redirect_pc;
        if (bus.mem_ack) begin
          w_state_nxt  = IFQ_REQ;
          w_req_pc_nxt = bus.redirect ? bus.redirect_pc : r_fetch_pc;
        end
      end
      default: w_state_nxt = IFQ_IDLE;
    endcase
  end

  assign bus.mem_req  = (r_state != IFQ_IDLE);
  assign bus.mem_addr = r_req_pc[IM_AW-1:0];
  assign bus.out_inst = w_head.inst;
  assign bus.out_pc   = w_head.pc;

endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue: program-order PC model, latency-randomised memory, random redirects.
module tb_ifetch_queue;
  import ifetch_queue_pkg::*;

  localparam int          DEPTH    = 4;
  localparam int          IM_AW    = 8;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  ifetch_queue_if #(.IM_AW(IM_AW)) bus();

  ifetch_queue #(
    .DEPTH    (DEPTH),
    .IM_AW    (IM_AW),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [IM_AW-1:0] a);
    logic [7:0] b;
    b = 8'(a);
    return {b ^ 8'hA5, ~b, b, b + 8'h3C};
  endfunction

  // reference model: program-order PC, epoch per redirect, expected queue contents
  ifq_entry_t       sb[$];
  ifq_entry_t       ent;
  logic [31:0]      exp_pc = RESET_PC;
  int               epoch = 0;
  int               req_epoch = 0;
  bit               req_active = 0;
  logic [IM_AW-1:0] req_addr = '0;
  bit               first_cycle = 1;

  // memory responder controls
  bit ack_idle_high = 1;
  int lat_fixed = 0;
  int wait_cnt = 0;
  int cur_lat = 0;
  bit found;
  logic [31:0] rpc;
  logic [31:0] tgt;

  function automatic int pick_lat();
    if (lat_fixed >= 0) return lat_fixed;
    return int'($urandom_range(0, 3));
  endfunction

  initial begin
    bus.mem_ack  = 1'b0;
    bus.mem_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        bus.mem_ack = 1'b0;
        wait_cnt    = 0;
        cur_lat     = pick_lat();
      end else if (bus.mem_req) begin
        if (wait_cnt >= cur_lat) begin
          bus.mem_ack  = 1'b1;
          bus.mem_data = inst_of(bus.mem_addr);
          wait_cnt     = 0;
          cur_lat      = pick_lat();
        end else begin
          bus.mem_ack  = 1'b0;
          bus.mem_data = $urandom;
          wait_cnt++;
        end
      end else begin
        bus.mem_ack  = ack_idle_high;
        bus.mem_data = $urandom;
        wait_cnt     = 0;
      end
    end
  end

  // output monitor: compares the presented head against the scoreboard and retires pops
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("out_valid", 32'(bus.out_valid), 32'(sb.size() != 0 && !bus.redirect));
        if (bus.out_valid && sb.size() != 0) begin
          chk("out_pc", bus.out_pc, sb[0].pc);
          chk("out_inst", bus.out_inst, sb[0].inst);
        end
        if (!bus.mem_req && !first_cycle)
          chk("idle_only_when_full", 32'(sb.size()), 32'(DEPTH));
        if (bus.out_valid && bus.out_ready && sb.size() != 0) void'(sb.pop_front());
      end
    end
  end

  // request tracker: decides which acks are kept and pushes the expected entry
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        sb.delete();
        exp_pc      = RESET_PC;
        req_active  = 0;
        first_cycle = 1;
        epoch++;
      end else begin
        if (req_active) begin
          chk("req_held", 32'(bus.mem_req), 32'd1);
          chk("req_addr_held", 32'(bus.mem_addr), 32'(req_addr));
        end else if (bus.mem_req) begin
          req_active = 1;
          req_epoch  = epoch;
          req_addr   = bus.mem_addr;
          chk("req_with_room", 32'(sb.size() < DEPTH), 32'd1);
        end
        if (req_active && bus.mem_ack) begin
          if (!bus.redirect && req_epoch == epoch) begin
            chk("fetch_addr", 32'(bus.mem_addr), 32'(exp_pc[IM_AW-1:0]));
            ent.pc   = exp_pc;
            ent.inst = inst_of(exp_pc[IM_AW-1:0]);
            sb.push_back(ent);
            exp_pc = exp_pc + 32'd4;
          end
          req_active = 0;
        end
        if (bus.redirect) begin
          sb.delete();
          exp_pc = bus.redirect_pc;
          epoch++;
        end
        first_cycle = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.out_ready   = 1'b1;
    rpc             = RESET_PC;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // reset release with zero-wait memory and always-ready consumer
    step();
    chk("p1_req_first_edge", 32'(bus.mem_req), 32'd1);
    chk("p1_no_valid_yet", 32'(bus.out_valid), 32'd0);
    step();
    chk("p1_first_valid", 32'(bus.out_valid), 32'd1);
    chk("p1_pc0", bus.out_pc, 32'h0);
    for (int k = 1; k < 4; k++) begin
      step();
      chk("p1_stream_pc", bus.out_pc, 32'(4 * k));
    end

    // fill to DEPTH with a stalled consumer, then release one entry
    bus.out_ready   = 1'b0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h100;
    step();
    bus.redirect    = 1'b0;
    bus.redirect_pc = $urandom;
    repeat (8) step();
    chk("p2_full_no_req", 32'(bus.mem_req), 32'd0);
    chk("p2_head_pc", bus.out_pc, 32'h100);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("p2_req_after_pop", 32'(bus.mem_req), 32'd1);
    chk("p2_next_addr", 32'(bus.mem_addr), 32'h10);
    chk("p2_head_after_pop", bus.out_pc, 32'h104);

    // slow memory
    bus.out_ready = 1'b1;
    lat_fixed     = 3;
    ack_idle_high = 0;
    repeat (30) step();

    // redirect while a slow request is waiting
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (bus.mem_req && !bus.mem_ack) found = 1;
      else step();
    end
    chk("p4_found_wait", 32'(found), 32'd1);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h40;
    step();
    bus.redirect = 1'b0;
    chk("p4_req_kept_high", 32'(bus.mem_req), 32'd1);
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (bus.out_valid) found = 1;
      else step();
    end
    chk("p4_valid_seen", 32'(found), 32'd1);
    chk("p4_first_pc", bus.out_pc, 32'h40);

    // redirect coinciding with ack and pop
    lat_fixed     = 0;
    ack_idle_high = 1;
    repeat (6) step();
    chk("p5_pre_valid", 32'(bus.out_valid), 32'd1);
    chk("p5_pre_ack", 32'(bus.mem_ack), 32'd1);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h80;
    #1;
    chk("p5_valid_masked", 32'(bus.out_valid), 32'd0);
    step();
    bus.redirect = 1'b0;
    chk("p5_req_target", 32'(bus.mem_req), 32'd1);
    chk("p5_addr_target", 32'(bus.mem_addr), 32'h80);
    step();
    chk("p5_valid_target", 32'(bus.out_valid), 32'd1);
    chk("p5_pc_target", bus.out_pc, 32'h80);

    // randomised traffic, including targets that wrap past 32'hFFFF_FFFC
    lat_fixed = -1;
    for (int k = 0; k < 2000; k++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      ack_idle_high = bit'($urandom_range(0, 1));
      bus.redirect  = ($urandom_range(0, 24) == 0);
      case ($urandom_range(0, 2))
        0:       tgt = {$urandom, 2'b00} ;
        1:       tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
        default: tgt = 32'h40;
      endcase
      bus.redirect_pc = tgt;
      step();
    end
    bus.redirect = 1'b0;
    repeat (10) step();

    // asynchronous reset in the middle of a request with entries queued
    bus.out_ready = 1'b0;
    lat_fixed     = 2;
    ack_idle_high = 0;
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (bus.out_valid && bus.mem_req && !bus.mem_ack) found = 1;
      else step();
    end
    chk("p7_found_busy", 32'(found), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("p7_req_dropped", 32'(bus.mem_req), 32'd0);
    chk("p7_valid_dropped", 32'(bus.out_valid), 32'd0);
    chk("p7_out_pc_zero", bus.out_pc, 32'h0);
    chk("p7_out_inst_zero", bus.out_inst, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    step();
    chk("p7_restart_req", 32'(bus.mem_req), 32'd1);
    chk("p7_restart_addr", 32'(bus.mem_addr), 32'(rpc[IM_AW-1:0]));
    bus.out_ready = 1'b1;
    lat_fixed     = 0;
    repeat (20) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
